sonic_rx_block_sync_66: RTL and testbench

Block synchronizer between the RX gearbox and the RX circular-buffer control stage. It checks the 2-bit sync header of each 66-bit block from the gearbox and runs the 10GBASE-R style lock state machine. It requests a bit slip from the gearbox while unlocked. It produces the registered data and write request (wrreq) that feed the RX buffer write port, and the block_lock status.

---
 rtl/sonic_constants.sv | 18 +
 rtl/sonic_sync_header_check.sv | 11 +
 rtl/sonic_rx_block_sync_66.sv | 144 ++++++++++++++
 tb/tb_sonic_rx_block_sync_66.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_constants.sv
// Shared constants for the SONIC 66-bit block path: sync headers, lock FSM
// states and default lock/slip timing.
package sonic_constants;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    LOCKED = 2'd1,
    SLIP   = 2'd2
  } sync_state_t;

  localparam int LOCK_CNT_DEF   = 64;
  localparam int BAD_SH_MAX_DEF = 16;
  localparam int SLIP_WAIT_DEF  = 32;

endpackage

// File: rtl/sonic_sync_header_check.sv
// Combinational 66b sync-header validity check, shared by the RX and TX paths.
module sonic_sync_header_check
  import sonic_constants::*;
(
  input  logic [1:0] header,
  output logic       sh_valid
);

  assign sh_valid = (header == SYNC_DATA) || (header == SYNC_CTRL);

endmodule

// File: rtl/sonic_rx_block_sync_66.sv
// RX block synchronizer: sync-header lock FSM, gearbox slip request and the
// registered write port into the RX circular buffer.
//
// state  | meaning
// UNLOCK | hunting: counting consecutive valid headers, slip on first bad one
// LOCKED | locked: 64-block test windows, lose lock on 16 bad headers in one
// SLIP   | waiting SLIP_WAIT cycles for the gearbox to realign, input ignored
module sonic_rx_block_sync_66
  import sonic_constants::*;
#(
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int BAD_SH_MAX = BAD_SH_MAX_DEF,
  parameter int SLIP_WAIT  = SLIP_WAIT_DEF,
  parameter int CNT_WIDTH  = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [65:0] data_in,
  input  logic        data_valid,
  output logic [65:0] data_out,
  output logic        wrreq,
  output logic        block_lock,
  output logic        slip,
  output logic [15:0] lock_loss_count
);

  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_WIDTH-1:0] LOCK_TC = CNT_WIDTH'(LOCK_CNT);
  localparam logic [CNT_WIDTH-1:0] BAD_TC  = CNT_WIDTH'(BAD_SH_MAX);
  localparam logic [WAIT_W-1:0]    WAIT_TC = WAIT_W'(SLIP_WAIT - 1);

  sync_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d, bad_cnt_inc;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [65:0]          data_d;
  logic                 lock_d, slip_d, wrreq_d;
  logic [15:0]          loss_d;
  logic                 sh_valid;

  sonic_sync_header_check u_sh_check (
    .header   (data_in[1:0]),
    .sh_valid (sh_valid)
  );

  assign sh_cnt_inc  = sh_cnt_q + 1'b1;
  assign bad_cnt_inc = bad_cnt_q + {{(CNT_WIDTH-1){1'b0}}, ~sh_valid};

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    wait_cnt_d = wait_cnt_q;
    lock_d     = block_lock;
    slip_d     = 1'b0;
    wrreq_d    = 1'b0;
    loss_d     = lock_loss_count;
    data_d     = data_out;

    if (data_valid) data_d = data_in;

    unique case (state_q)
      UNLOCK: begin
        if (data_valid) begin
          if (sh_valid) begin
            sh_cnt_d = sh_cnt_inc;
            if (sh_cnt_inc == LOCK_TC) begin
              lock_d    = 1'b1;
              state_d   = LOCKED;
              sh_cnt_d  = '0;
              bad_cnt_d = '0;
            end
          end else begin
            slip_d    = 1'b1;
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
            state_d   = SLIP;
          end
        end
      end
      LOCKED: begin
        if (data_valid) begin
          sh_cnt_d  = sh_cnt_inc;
          bad_cnt_d = bad_cnt_inc;
          // Loss of lock takes priority over the end-of-window clear.
          if (bad_cnt_inc == BAD_TC) begin
            lock_d    = 1'b0;
            slip_d    = 1'b1;
            loss_d    = (lock_loss_count == 16'hFFFF) ? lock_loss_count
                                                      : lock_loss_count + 16'd1;
            state_d   = SLIP;
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
          end else begin
            wrreq_d = block_lock;
            if (sh_cnt_inc == LOCK_TC) begin
              sh_cnt_d  = '0;
              bad_cnt_d = '0;
            end
          end
        end
      end
      SLIP: begin
        if (wait_cnt_q == WAIT_TC) begin
          wait_cnt_d = '0;
          state_d    = UNLOCK;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = UNLOCK;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state_q    <= UNLOCK;
      sh_cnt_q   <= '0;
      bad_cnt_q  <= '0;
      wait_cnt_q <= '0;
      data_out   <= '0;
      wrreq      <= 1'b0;
      block_lock <= 1'b0;
      slip       <= 1'b0;
      // Disabling the link keeps the loss history; only reset clears it.
      if (reset) lock_loss_count <= '0;
    end else begin
      state_q         <= state_d;
      sh_cnt_q        <= sh_cnt_d;
      bad_cnt_q       <= bad_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      data_out        <= data_d;
      wrreq           <= wrreq_d;
      block_lock      <= lock_d;
      slip            <= slip_d;
      lock_loss_count <= loss_d;
    end
  end

endmodule

// File: tb/tb_sonic_rx_block_sync_66.sv
// Self-checking bench for sonic_rx_block_sync_66: behavioural scoreboard on
// every cycle plus directed checks for lock, slip, window and control cases.
module tb_sonic_rx_block_sync_66;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [65:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic [65:0] data_out;
  logic        wrreq;
  logic        block_lock;
  logic        slip;
  logic [15:0] lock_loss_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [65:0] d;
    logic        wr;
    logic        lock;
    logic        slp;
    logic [15:0] llc;
  } exp_t;

  exp_t sb[$];

  localparam int M_HUNT = 0, M_LOCK = 1, M_SLIP = 2;
  int          m_state = M_HUNT;
  int          m_good = 0, m_bad = 0, m_wait = 0;
  logic        m_lock = 1'b0;
  logic [15:0] m_llc = '0;
  logic [65:0] m_dout = '0;

  sonic_rx_block_sync_66 dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .data_out        (data_out),
    .wrreq           (wrreq),
    .block_lock      (block_lock),
    .slip            (slip),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clock = ~clock;

  function automatic logic [65:0] blk(input logic [1:0] h);
    blk = {$urandom(), $urandom(), h};
  endfunction

  // Reference behaviour: expected registered outputs after one clock edge.
  task automatic model(input logic r, input logic en, input logic dv,
                       input logic [65:0] din, output exp_t e);
    logic hv;
    hv = (din[1:0] == 2'b01) || (din[1:0] == 2'b10);
    e.slp = 1'b0;
    e.wr  = 1'b0;
    if (r || !en) begin
      m_state = M_HUNT; m_good = 0; m_bad = 0; m_wait = 0;
      m_lock = 1'b0; m_dout = '0;
      if (r) m_llc = '0;
    end else begin
      if (dv) m_dout = din;
      if (m_state == M_HUNT) begin
        if (dv && hv) begin
          m_good++;
          if (m_good == 64) begin
            m_lock = 1'b1; m_state = M_LOCK; m_good = 0; m_bad = 0;
          end
        end else if (dv) begin
          e.slp = 1'b1; m_good = 0; m_bad = 0; m_state = M_SLIP;
        end
      end else if (m_state == M_LOCK) begin
        if (dv) begin
          m_good++;
          if (!hv) m_bad++;
          if (m_bad == 16) begin
            m_lock = 1'b0; e.slp = 1'b1; m_state = M_SLIP;
            m_good = 0; m_bad = 0;
            if (m_llc != 16'hFFFF) m_llc++;
          end else begin
            e.wr = 1'b1;
            if (m_good == 64) begin m_good = 0; m_bad = 0; end
          end
        end
      end else begin
        if (m_wait == 31) begin m_wait = 0; m_state = M_HUNT; end
        else m_wait++;
      end
    end
    e.d    = m_dout;
    e.lock = m_lock;
    e.llc  = m_llc;
  endtask

  task automatic cycle(input logic r, input logic en, input logic dv,
                       input logic [65:0] din);
    exp_t e;
    reset = r; enable = en; data_valid = dv; data_in = din;
    model(r, en, dv, din, e);
    sb.push_back(e);
    @(posedge clock);
    #2;
  endtask

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      exp_t got;
      e   = sb.pop_front();
      got = '{d: data_out, wr: wrreq, lock: block_lock, slp: slip, llc: lock_loss_count};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got d=%h wr=%b lock=%b slip=%b llc=%0d want d=%h wr=%b lock=%b slip=%b llc=%0d",
                 $time, got.d, got.wr, got.lock, got.slp, got.llc,
                 e.d, e.wr, e.lock, e.slp, e.llc);
      end
    end
  end

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic acquire(input string name);
    for (int i = 0; i < 64; i++) begin
      cycle(0, 1, 1, blk(i[0] ? 2'b10 : 2'b01));
      if (i == 62) begin
        checks++;
        if (block_lock !== 1'b0) begin
          errors++; $display("FAIL %s_early_lock got %b want 0", name, block_lock);
        end
      end
    end
    checks++;
    if (block_lock !== 1'b1) begin
      errors++; $display("FAIL %s_lock got %b want 1", name, block_lock);
    end
  endtask

  task automatic test_reset;
    cycle(1, 1, 1, blk(2'b01));
    cycle(1, 1, 0, blk(2'b11));
    checks++;
    if ({block_lock, slip, wrreq} !== 3'b000 || data_out !== 66'd0 || lock_loss_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got lock=%b slip=%b wr=%b d=%h llc=%0d want all 0",
               block_lock, slip, wrreq, data_out, lock_loss_count);
    end
  endtask

  task automatic test_acquire;
    int slips;
    slips = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(0, 1, 1, blk(2'b01));
      if (slip) slips++;
      if (i == 62) begin
        checks++;
        if (block_lock !== 1'b0) begin
          errors++; $display("FAIL acq_early_lock got %b want 0", block_lock);
        end
      end
    end
    checks++;
    if (block_lock !== 1'b1 || wrreq !== 1'b0) begin
      errors++; $display("FAIL acq_lock_64 got lock=%b wr=%b want lock=1 wr=0", block_lock, wrreq);
    end
    cycle(0, 1, 1, blk(2'b01));
    checks++;
    if (wrreq !== 1'b1) begin
      errors++; $display("FAIL acq_wrreq_65 got %b want 1", wrreq);
    end
    checks++;
    if (slips != 0) begin
      errors++; $display("FAIL acq_no_slip got %0d slips want 0", slips);
    end
  endtask

  task automatic test_slip;
    int slips;
    slips = 0;
    cycle(1, 1, 0, '0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, blk(2'b10));
    cycle(0, 1, 1, blk(2'b11));
    chk("slip_pulse", {65'd0, slip}, 66'd1);
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, 1, blk(2'b11));
      if (slip) slips++;
    end
    checks++;
    if (slips != 0) begin
      errors++; $display("FAIL slip_ignored_window got %0d slips want 0", slips);
    end
    acquire("slip_relock");
  endtask

  task automatic test_bad_window;
    for (int i = 0; i < 64; i++)
      cycle(0, 1, 1, blk((i % 4 == 0 && i < 60) ? 2'b11 : 2'b01));
    chk("win15_hold", {65'd0, block_lock}, 66'd1);
    for (int i = 0; i <= 45; i++) begin
      cycle(0, 1, 1, blk((i % 3 == 0) ? 2'b00 : 2'b10));
      if (i == 44) chk("win16_hold_before", {65'd0, block_lock}, 66'd1);
    end
    checks++;
    if (block_lock !== 1'b0 || slip !== 1'b1 || wrreq !== 1'b0 || lock_loss_count !== 16'd1) begin
      errors++;
      $display("FAIL win16_loss got lock=%b slip=%b wr=%b llc=%0d want lock=0 slip=1 wr=0 llc=1",
               block_lock, slip, wrreq, lock_loss_count);
    end
  endtask

  task automatic test_priority;
    for (int i = 0; i < 32; i++) cycle(0, 1, 0, blk(2'b11));
    acquire("prio_lock");
    for (int i = 0; i < 64; i++) begin
      cycle(0, 1, 1, blk((i >= 48) ? 2'b11 : 2'b01));
      if (i == 62) chk("prio_hold_63", {65'd0, block_lock}, 66'd1);
    end
    checks++;
    if (block_lock !== 1'b0 || slip !== 1'b1 || wrreq !== 1'b0 || lock_loss_count !== 16'd2) begin
      errors++;
      $display("FAIL prio_loss got lock=%b slip=%b wr=%b llc=%0d want lock=0 slip=1 wr=0 llc=2",
               block_lock, slip, wrreq, lock_loss_count);
    end
  endtask

  task automatic test_enable_low;
    cycle(0, 0, 1, blk(2'b01));
    checks++;
    if (block_lock !== 1'b0 || slip !== 1'b0 || wrreq !== 1'b0 || lock_loss_count !== 16'd2) begin
      errors++;
      $display("FAIL en_low_slip got lock=%b slip=%b wr=%b llc=%0d want 0 0 0 2",
               block_lock, slip, wrreq, lock_loss_count);
    end
    acquire("en_slip_relock");
    cycle(0, 0, 1, blk(2'b01));
    checks++;
    if (block_lock !== 1'b0 || wrreq !== 1'b0 || lock_loss_count !== 16'd2) begin
      errors++;
      $display("FAIL en_low_locked got lock=%b wr=%b llc=%0d want 0 0 2",
               block_lock, wrreq, lock_loss_count);
    end
    acquire("en_locked_relock");
  endtask

  task automatic test_reset_mid;
    cycle(1, 1, 1, blk(2'b01));
    checks++;
    if (block_lock !== 1'b0 || wrreq !== 1'b0 || lock_loss_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_locked got lock=%b wr=%b llc=%0d want 0 0 0",
               block_lock, wrreq, lock_loss_count);
    end
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, blk(2'b01));
    cycle(0, 1, 1, blk(2'b00));
    chk("rst_pre_slip", {65'd0, slip}, 66'd1);
    cycle(1, 1, 1, blk(2'b01));
    checks++;
    if (block_lock !== 1'b0 || slip !== 1'b0 || wrreq !== 1'b0) begin
      errors++;
      $display("FAIL rst_slip got lock=%b slip=%b wr=%b want 0 0 0", block_lock, slip, wrreq);
    end
    acquire("rst_slip_relock");
  endtask

  task automatic test_gaps;
    logic [65:0] last;
    cycle(1, 1, 0, '0);
    for (int i = 0; i < 64; i++) begin
      last = blk(2'b01);
      cycle(0, 1, 1, last);
      if (i == 62) chk("gap_early_lock", {65'd0, block_lock}, 66'd0);
      cycle(0, 1, 0, blk(2'b11));
      if (i % 16 == 0) chk("gap_data_hold", data_out, last);
    end
    chk("gap_lock_64", {65'd0, block_lock}, 66'd1);
  endtask

  initial begin
    test_reset;
    test_acquire;
    test_slip;
    test_bad_window;
    test_priority;
    test_enable_low;
    test_reset_mid;
    test_gaps;
    @(posedge clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
